// File: rtl/tank_monitor_sequencer_if.sv
// -----------------------------------------------------------------------------
// tank_monitor_sequencer_if
//   Bundles the control handshake, the four registered tank readings and the
//   status outputs of the aquarium monitor sequencer.
//
//   Signals
//     start       master->slave  1  begin scanning (honoured only while idle)
//     stop        master->slave  1  finish the current slot, then go idle
//     err_clear   master->slave  1  request exit from error mode
//     q_clean     master->slave  8  registered cleanliness reading
//     q_temp      master->slave  8  registered temperature reading
//     q_food      master->slave  8  registered food storage reading
//     q_salt      master->slave  8  registered saltiness reading
//     select      slave->master  5  one-hot display mux select (11111 = error)
//     scan_count  slave->master  8  completed full scans (mux input1)
//     busy        slave->master  1  sequencer not idle
//     error       slave->master  1  sequencer in error mode
//     error_code  slave->master  4  sticky violations {salt, food, temp, clean}
// -----------------------------------------------------------------------------
interface tank_monitor_sequencer_if;
    logic       start;
    logic       stop;
    logic       err_clear;
    logic [7:0] q_clean;
    logic [7:0] q_temp;
    logic [7:0] q_food;
    logic [7:0] q_salt;
    logic [4:0] select;
    logic [7:0] scan_count;
    logic       busy;
    logic       error;
    logic [3:0] error_code;

    // Controller / testbench side: drives requests and readings.
    modport master (
        output start, stop, err_clear,
        output q_clean, q_temp, q_food, q_salt,
        input  select, scan_count, busy, error, error_code
    );

    // Sequencer side: consumes requests and readings, drives status.
    modport slave (
        input  start, stop, err_clear,
        input  q_clean, q_temp, q_food, q_salt,
        output select, scan_count, busy, error, error_code
    );
endinterface

// File: rtl/tank_monitor_sequencer.sv
// -----------------------------------------------------------------------------
// tank_monitor_sequencer
//   Sequences the aquarium status display mux through the counter slot and
//   the four sensor slots, holding each slot for DWELL cycles. Every reading
//   is checked against its limits while a slot is displayed; any violation
//   forces error mode (select = 11111) until it is cleared with no violation
//   present. Completed scans are counted and presented on scan_count.
//
//   Ports
//     CLK    in  1  system clock, rising edge
//     reset  in  1  asynchronous active-low reset
//     bus    slave modport of tank_monitor_sequencer_if (see interface file)
//
//   All outputs are registered; select/busy/error are computed from the
//   next state so they change on the same edge as the state itself.
// -----------------------------------------------------------------------------
module tank_monitor_sequencer #(
    parameter int unsigned DWELL     = 4,
    parameter logic [7:0]  CLEAN_MIN = 8'd10,
    parameter logic [7:0]  TEMP_MIN  = 8'd20,
    parameter logic [7:0]  TEMP_MAX  = 8'd30,
    parameter logic [7:0]  FOOD_MIN  = 8'd5,
    parameter logic [7:0]  SALT_MAX  = 8'd120
) (
    input  logic                       CLK,
    input  logic                       reset,
    tank_monitor_sequencer_if.slave    bus
);

    // Dwell counter is at least one bit wide so DWELL == 1 still elaborates.
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [DW-1:0] DWELL_ZERO = DW'(0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_CLEAN = 3'd2;
    localparam logic [2:0] S_TEMP  = 3'd3;
    localparam logic [2:0] S_FOOD  = 3'd4;
    localparam logic [2:0] S_SALT  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    // Mux select code shown for a given state.
    function automatic logic [4:0] select_of(input logic [2:0] st);
        logic [4:0] code;
        case (st)
            S_IDLE:  code = 5'b00000;
            S_COUNT: code = 5'b00001;
            S_CLEAN: code = 5'b00010;
            S_TEMP:  code = 5'b00100;
            S_FOOD:  code = 5'b01000;
            S_SALT:  code = 5'b10000;
            S_ERROR: code = 5'b11111;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    // Display slot that follows the given one in the scan ring.
    function automatic logic [2:0] next_slot(input logic [2:0] st);
        logic [2:0] nxt;
        case (st)
            S_COUNT: nxt = S_CLEAN;
            S_CLEAN: nxt = S_TEMP;
            S_TEMP:  nxt = S_FOOD;
            S_FOOD:  nxt = S_SALT;
            S_SALT:  nxt = S_COUNT;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    logic [2:0]    state_q,        state_d;
    logic [DW-1:0] dwell_q,        dwell_d;
    logic          stop_pending_q, stop_pending_d;
    logic [7:0]    scan_count_q,   scan_count_d;
    logic [3:0]    error_code_q,   error_code_d;
    logic [4:0]    select_q,       select_d;
    logic          busy_q,         busy_d;
    logic          error_q,        error_d;

    logic [3:0]    viol_s;
    logic          any_viol_s;
    logic          is_display_s;

    // Limit checks on the live readings; bit order matches error_code.
    always_comb begin
        viol_s    = 4'b0000;
        viol_s[0] = (bus.q_clean < CLEAN_MIN);
        viol_s[1] = (bus.q_temp < TEMP_MIN) || (bus.q_temp > TEMP_MAX);
        viol_s[2] = (bus.q_food < FOOD_MIN);
        viol_s[3] = (bus.q_salt > SALT_MAX);
        any_viol_s = |viol_s;
    end

    // Flags the five display slots, where limit checks are armed.
    always_comb begin
        case (state_q)
            S_COUNT, S_CLEAN, S_TEMP, S_FOOD, S_SALT: is_display_s = 1'b1;
            default:                                  is_display_s = 1'b0;
        endcase
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        dwell_d        = dwell_q;
        stop_pending_d = stop_pending_q;
        scan_count_d   = scan_count_q;
        error_code_d   = error_code_q;

        if (state_q == S_IDLE) begin
            // stop and err_clear have no meaning while idle.
            stop_pending_d = 1'b0;
            if (bus.start) begin
                state_d = S_COUNT;
                dwell_d = DWELL_ZERO;
            end else begin
                state_d = S_IDLE;
            end
        end else if (is_display_s) begin
            if (any_viol_s) begin
                // A violation outranks both slot expiry and a pending stop.
                state_d        = S_ERROR;
                error_code_d   = viol_s;
                stop_pending_d = 1'b0;
                dwell_d        = DWELL_ZERO;
            end else if (dwell_q == DWELL_LAST) begin
                dwell_d        = DWELL_ZERO;
                stop_pending_d = 1'b0;
                // Leaving SALT completes a scan, whether or not we stop.
                if (state_q == S_SALT) begin
                    scan_count_d = scan_count_q + 8'd1;
                end else begin
                    scan_count_d = scan_count_q;
                end
                // A stop raised on the final dwell cycle still ends this slot.
                if (stop_pending_q || bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = next_slot(state_q);
                end
            end else begin
                dwell_d = dwell_q + DWELL_ONE;
                if (bus.stop) begin
                    stop_pending_d = 1'b1;
                end else begin
                    stop_pending_d = stop_pending_q;
                end
            end
        end else if (state_q == S_ERROR) begin
            error_code_d = error_code_q | viol_s;
            if (bus.err_clear && !any_viol_s) begin
                state_d      = S_IDLE;
                error_code_d = 4'b0000;
                dwell_d      = DWELL_ZERO;
                scan_count_d = 8'd0;
            end else begin
                state_d = S_ERROR;
            end
        end else begin
            // Unreachable encodings fall back to a clean idle.
            state_d        = S_IDLE;
            dwell_d        = DWELL_ZERO;
            stop_pending_d = 1'b0;
            error_code_d   = 4'b0000;
        end

        select_d = select_of(state_d);
        busy_d   = (state_d != S_IDLE);
        error_d  = (state_d == S_ERROR);
    end

    // State and registered outputs with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            dwell_q        <= DWELL_ZERO;
            stop_pending_q <= 1'b0;
            scan_count_q   <= 8'd0;
            error_code_q   <= 4'b0000;
            select_q       <= 5'b00000;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            stop_pending_q <= stop_pending_d;
            scan_count_q   <= scan_count_d;
            error_code_q   <= error_code_d;
            select_q       <= select_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
        end
    end

    assign bus.select     = select_q;
    assign bus.scan_count = scan_count_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
    assign bus.error_code = error_code_q;

endmodule

// File: tb/tb_tank_monitor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tank_monitor_sequencer
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model that tracks the sequencer as a mode
//   (idle / running / error), a slot index in the scan ring, cycles spent in
//   the slot, a stop request flag, a scan total and a sticky violation mask.
// -----------------------------------------------------------------------------
module tb_tank_monitor_sequencer;
    localparam int DWELL = 4;

    logic CLK;
    logic reset;
    tank_monitor_sequencer_if bus();

    tank_monitor_sequencer #(.DWELL(DWELL)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    int         m_mode;
    int         m_slot;      // 0 counter, 1 clean, 2 temp, 3 food, 4 salt
    int         m_held;      // cycles already spent in the current slot
    bit         m_stop_req;
    int         m_count;
    logic [3:0] m_code;

    function automatic logic [3:0] limits_broken(input int c, input int t, input int f, input int s);
        logic [3:0] v;
        v    = 4'b0000;
        v[0] = (c < 10);
        v[1] = (t < 20) || (t > 30);
        v[2] = (f < 5);
        v[3] = (s > 120);
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_slot = 0; m_held = 0; m_stop_req = 1'b0;
        m_count = 0; m_code = 4'b0000;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        logic [3:0] v;
        v = limits_broken(int'(bus.q_clean), int'(bus.q_temp), int'(bus.q_food), int'(bus.q_salt));
        if (m_mode == M_IDLE) begin
            m_stop_req = 1'b0;
            if (bus.start) begin
                m_mode = M_RUN; m_slot = 0; m_held = 0;
            end
        end else if (m_mode == M_RUN) begin
            if (v != 4'b0000) begin
                m_mode = M_ERR; m_code = v; m_stop_req = 1'b0; m_held = 0;
            end else if (m_held + 1 == DWELL) begin
                if (m_slot == 4) m_count = (m_count + 1) % 256;
                if (m_stop_req || bus.stop) begin
                    m_mode = M_IDLE; m_stop_req = 1'b0;
                end else begin
                    m_slot = (m_slot + 1) % 5;
                end
                m_held = 0;
            end else begin
                m_held = m_held + 1;
                if (bus.stop) m_stop_req = 1'b1;
            end
        end else begin
            m_code = m_code | v;
            if (bus.err_clear && v == 4'b0000) begin
                m_mode = M_IDLE; m_code = 4'b0000; m_count = 0; m_held = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [4:0] exp_sel;
        if (m_mode == M_IDLE)      exp_sel = 5'b00000;
        else if (m_mode == M_ERR)  exp_sel = 5'b11111;
        else                       exp_sel = 5'(5'b00001 << m_slot);
        check_eq("select",     32'(bus.select),     32'(exp_sel));
        check_eq("scan_count", 32'(bus.scan_count), 32'(m_count));
        check_eq("busy",       32'(bus.busy),       32'(m_mode != M_IDLE));
        check_eq("error",      32'(bus.error),      32'(m_mode == M_ERR));
        check_eq("error_code", 32'(bus.error_code), 32'(m_code));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    task automatic set_inputs(input int c, input int t, input int f, input int s);
        bus.q_clean = 8'(c); bus.q_temp = 8'(t); bus.q_food = 8'(f); bus.q_salt = 8'(s);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
    endtask

    // Run until the model shows the given slot/dwell position, bounded.
    task automatic wait_slot(input int slot, input int held);
        int budget;
        bit found;
        budget = 200;
        found  = (m_mode == M_RUN && m_slot == slot && m_held == held);
        while (!found && budget > 0) begin
            cycle();
            budget--;
            found = (m_mode == M_RUN && m_slot == slot && m_held == held);
        end
        check_eq("wait_slot_reached", 32'(found), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.err_clear = 1'b0;
        set_inputs(14, 28, 56, 112);
        model_reset();
        repeat (2) @(negedge CLK);
        compare_all();
        reset = 1'b1;

        // 1: idle with no start for ten cycles.
        repeat (10) cycle();

        // 2: a full scan with in-range readings.
        pulse_start();
        check_eq("t2_first_slot", 32'(bus.select), 32'd1);
        repeat (4 * DWELL) cycle();
        check_eq("t2_salt_slot", 32'(bus.select), 32'h10);
        repeat (DWELL) cycle();
        check_eq("t2_wrap_sel", 32'(bus.select), 32'd1);
        check_eq("t2_wrap_cnt", 32'(bus.scan_count), 32'd1);

        // 3: temperature violation in the food slot, then clearing.
        wait_slot(3, 0);
        bus.q_temp = 8'd35;
        cycle();
        check_eq("t3_err_sel",  32'(bus.select), 32'h1f);
        check_eq("t3_err_code", 32'(bus.error_code), 32'h2);
        bus.err_clear = 1'b1;
        cycle();
        check_eq("t3_stuck", 32'(bus.error), 32'd1);
        bus.q_temp = 8'd28;
        cycle();
        bus.err_clear = 1'b0;
        check_eq("t3_clear_sel",  32'(bus.select), 32'd0);
        check_eq("t3_clear_code", 32'(bus.error_code), 32'd0);
        check_eq("t3_clear_cnt",  32'(bus.scan_count), 32'd0);

        // 4: stop in the temperature slot, then stop in the salt slot.
        pulse_start();
        wait_slot(2, 1);
        bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
        cycle();
        check_eq("t4_hold_sel", 32'(bus.select), 32'h4);
        cycle();
        check_eq("t4_idle_sel",  32'(bus.select), 32'd0);
        check_eq("t4_idle_busy", 32'(bus.busy), 32'd0);
        pulse_start();
        wait_slot(4, 0);
        bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
        repeat (DWELL - 1) cycle();
        check_eq("t4_salt_idle", 32'(bus.busy), 32'd0);
        check_eq("t4_salt_cnt",  32'(bus.scan_count), 32'd1);

        // 5: asynchronous reset in the middle of the clean slot.
        pulse_start();
        wait_slot(1, 2);
        #2 reset = 1'b0;
        #1;
        check_eq("t5_async_sel",  32'(bus.select), 32'd0);
        check_eq("t5_async_cnt",  32'(bus.scan_count), 32'd0);
        check_eq("t5_async_busy", 32'(bus.busy), 32'd0);
        model_reset();
        @(negedge CLK);
        reset = 1'b1;
        cycle();

        // 6: 256 scans wrap the counter; stop and violation together.
        pulse_start();
        repeat (255 * 5 * DWELL) cycle();
        check_eq("t6_cnt_255", 32'(bus.scan_count), 32'd255);
        repeat (5 * DWELL) cycle();
        check_eq("t6_cnt_wrap", 32'(bus.scan_count), 32'd0);
        bus.stop = 1'b1; bus.q_salt = 8'd200;
        cycle();
        bus.stop = 1'b0;
        check_eq("t6_err_wins",  32'(bus.error), 32'd1);
        check_eq("t6_err_code",  32'(bus.error_code), 32'h8);
        bus.q_salt = 8'd120; bus.err_clear = 1'b1;
        cycle();
        bus.err_clear = 1'b0;

        // Randomized traffic, including limit boundary values.
        for (int n = 0; n < 3000; n++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.stop      = ($urandom_range(0, 15) == 0);
            bus.err_clear = ($urandom_range(0, 3) == 0);
            bus.q_clean = ($urandom_range(0, 59) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(10, 255));
            bus.q_temp  = ($urandom_range(0, 59) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(20, 30));
            bus.q_food  = ($urandom_range(0, 59) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(5, 255));
            bus.q_salt  = ($urandom_range(0, 59) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 120));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
